// File: rtl/karat_seq_mult_if.sv
// Operand/result handshake bundle for karat_seq_mult: valid/ready on the operand
// side, valid/ready on the product side, plus a busy status flag.
interface karat_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] C;
  logic               busy;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, C, busy
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, C, busy
  );
endinterface

// File: rtl/karat_seq_mult.sv
// Sequential Karatsuba multiplier: three half-width products on one shared (H+1)-bit
// multiplier, then recombined. Define KARAT_SIGNED_EN for two's-complement operands.
module karat_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  karat_seq_mult_if.slave  bus
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H + 2;
  localparam int SW = 2 * WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_LO  = 3'd1,
    P_HI  = 3'd2,
    P_MID = 3'd3,
    COMB  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*H-1:0]     z0_reg;
  logic [2*H-1:0]     z2_reg;
  logic [PW-1:0]      zm_reg;
  logic [2*WIDTH-1:0] c_reg;
  logic               out_valid_reg;

  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [H-1:0]       a0, a1, b0, b1;
  logic [H:0]         mul_x;
  logic [H:0]         mul_y;
  logic [PW-1:0]      mul_p;
  logic [PW-1:0]      z1;
  logic [SW-1:0]      sum;
  logic [2*WIDTH-1:0] c_res;

  assign accept = bus.in_valid && bus.in_ready;

`ifdef KARAT_SIGNED_EN
  logic sign_reg;
  // Magnitude of the most negative value wraps to itself, which is the correct unsigned value.
  assign a_mag = bus.A[WIDTH-1] ? (~bus.A + WIDTH'(1)) : bus.A;
  assign b_mag = bus.B[WIDTH-1] ? (~bus.B + WIDTH'(1)) : bus.B;
`else
  assign a_mag = bus.A;
  assign b_mag = bus.B;
`endif

  assign a0 = a_reg[H-1:0];
  assign a1 = a_reg[WIDTH-1:H];
  assign b0 = b_reg[H-1:0];
  assign b1 = b_reg[WIDTH-1:H];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = P_LO;
      P_LO:    state_next = P_HI;
      P_HI:    state_next = P_MID;
      P_MID:   state_next = COMB;
      COMB:    state_next = DONE;
      DONE:    if (out_valid_reg && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand steering for the single shared sub-multiplier
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_reg)
      P_LO: begin
        mul_x = {1'b0, a0};
        mul_y = {1'b0, b0};
      end
      P_HI: begin
        mul_x = {1'b0, a1};
        mul_y = {1'b0, b1};
      end
      P_MID: begin
        mul_x = {1'b0, a0} + {1'b0, a1};
        mul_y = {1'b0, b0} + {1'b0, b1};
      end
      default: begin
        mul_x = '0;
        mul_y = '0;
      end
    endcase
  end

  assign mul_p = PW'(mul_x) * PW'(mul_y);

  // zm >= z0 + z2 always holds, so this difference never wraps
  assign z1  = zm_reg - PW'(z0_reg) - PW'(z2_reg);
  assign sum = (SW'(z2_reg) << (2 * H)) + (SW'(z1) << H) + SW'(z0_reg);

`ifdef KARAT_SIGNED_EN
  logic [SW-1:0] sum_signed;
  assign sum_signed = sign_reg ? (~sum + SW'(1)) : sum;
  assign c_res      = sum_signed[2*WIDTH-1:0];
`else
  assign c_res = sum[2*WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      z0_reg        <= '0;
      z2_reg        <= '0;
      zm_reg        <= '0;
      c_reg         <= '0;
      out_valid_reg <= 1'b0;
`ifdef KARAT_SIGNED_EN
      sign_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg    <= a_mag;
            b_reg    <= b_mag;
`ifdef KARAT_SIGNED_EN
            sign_reg <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
          end
        end
        P_LO:  z0_reg <= mul_p[2*H-1:0];
        P_HI:  z2_reg <= mul_p[2*H-1:0];
        P_MID: zm_reg <= mul_p;
        COMB: begin
          c_reg         <= c_res;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.busy      = (state_reg != IDLE) && !rst;
  assign bus.out_valid = out_valid_reg && !rst;
  assign bus.C         = c_reg;
endmodule

// File: tb/tb_karat_seq_mult.sv
// Bench for karat_seq_mult: WIDTH=16 and WIDTH=8 instances checked against a plain
// integer multiply, with directed corners, backpressure, reset abort and random traffic.
module tb_karat_seq_mult;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  karat_seq_mult_if #(.WIDTH(16)) if16();
  karat_seq_mult_if #(.WIDTH(8))  if8();

  karat_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  karat_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product of two w-bit operands, as plain integers
  function automatic longint refmul(input longint a, input longint b, input int w);
    longint x;
    longint y;
    x = a;
    y = b;
`ifdef KARAT_SIGNED_EN
    if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
`endif
    return x * y;
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!if16.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!if16.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue16_ready_timeout in_ready=%b required 1", if16.in_ready);
    end
    if16.A = a;
    if16.B = b;
    if16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if16.in_valid = 1'b0;
    if16.A = 16'($urandom);
    if16.B = 16'($urandom);
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string name);
    issue16(a, b);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_valid edge+%0d out_valid=%b required 0", name, i, if16.out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency out_valid=%b required 1", name, if16.out_valid);
    end
    checks++;
    if (if16.C !== exp) begin
      errors++;
      $display("FAIL %s_result C=%h required %h", name, if16.C, exp);
    end
    $display("txn w16 %s A=%h B=%h C=%h", name, a, b, if16.C);
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%b in_ready=%b required 0 1",
               name, if16.out_valid, if16.in_ready);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!if8.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if8.A = a;
    if8.B = b;
    if8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (if8.out_valid !== 1'b1 || if8.C !== exp) begin
      errors++;
      $display("FAIL %s out_valid=%b C=%h required 1 %h", name, if8.out_valid, if8.C, exp);
    end
    $display("txn w8 %s A=%h B=%h C=%h", name, a, b, if8.C);
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b0 || if16.out_valid !== 1'b0 || if16.busy !== 1'b0 ||
        if16.C !== 32'h0 || if8.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold in_ready=%b out_valid=%b busy=%b C=%h required 0 0 0 0",
               if16.in_ready, if16.out_valid, if16.busy, if16.C);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if8.in_ready !== 1'b1 || if16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b/%b out_valid=%b required 1/1 0",
               if16.in_ready, if8.in_ready, if16.out_valid);
    end
    $display("txn reset done");
  endtask

  task automatic test_directed16();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] ve [4];
    va = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000};
    vb = '{16'h5678, 16'hFFFF, 16'h0002, 16'h8000};
`ifdef KARAT_SIGNED_EN
    ve = '{32'h06260060, 32'h00000001, 32'hFFFFFFFE, 32'h40000000};
`else
    ve = '{32'h06260060, 32'hFFFE0001, 32'h0001FFFE, 32'h40000000};
`endif
    for (int i = 0; i < 4; i++) run_op16(va[i], vb[i], ve[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_backpressure();
    issue16(16'h1234, 16'h5678);
    repeat (5) @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b1 || if16.C !== 32'h06260060) begin
      errors++;
      $display("FAIL bp_first out_valid=%b C=%h required 1 06260060", if16.out_valid, if16.C);
    end
    for (int i = 0; i < 3; i++) begin
      if16.in_valid = 1'b1;
      if16.A = 16'($urandom);
      if16.B = 16'($urandom);
      @(negedge clk);
      checks++;
      if (if16.out_valid !== 1'b1 || if16.C !== 32'h06260060 || if16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d out_valid=%b C=%h in_ready=%b required 1 06260060 0",
                 i, if16.out_valid, if16.C, if16.in_ready);
      end
    end
    // Release the result while a new operand pair is already being offered
    if16.A = 16'h0003;
    if16.B = 16'h0005;
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1 || if16.busy !== 1'b0 ||
        if16.C !== 32'h06260060) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b C=%h required 0 1 0 06260060",
               if16.out_valid, if16.in_ready, if16.busy, if16.C);
    end
    @(posedge clk);
    #1;
    if16.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_after busy=%b required 1", if16.busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b1 || if16.C !== 32'(refmul(64'd3, 64'd5, 16))) begin
      errors++;
      $display("FAIL bp_second out_valid=%b C=%h required 1 0000000f", if16.out_valid, if16.C);
    end
    $display("txn w16 backpressure C=%h", if16.C);
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    issue16(16'h1234, 16'h5678);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.C !== 32'h0 ||
        if16.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state in_ready=%b out_valid=%b C=%h busy=%b required 1 0 0 0",
               if16.in_ready, if16.out_valid, if16.C, if16.busy);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (if16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_result cycle %0d out_valid=%b required 0", i, if16.out_valid);
      end
    end
    run_op16(16'h0003, 16'h0005, 32'h0000000F, "after_abort");
  endtask

  task automatic test_w8();
`ifdef KARAT_SIGNED_EN
    run_op8(8'hFF, 8'hFF, 16'h0001, "w8_ffff");
`else
    run_op8(8'hFF, 8'hFF, 16'hFE01, "w8_ffff");
`endif
    run_op8(8'h00, 8'hAB, 16'h0000, "w8_zero");
  endtask

  task automatic test_random8(input int n);
    logic [15:0] q[$];
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int idle;
          int w;
          logic [7:0] a;
          logic [7:0] b;
          idle = $urandom_range(0, 3);
          w = 0;
          a = 8'($urandom);
          b = 8'($urandom);
          repeat (idle) @(negedge clk);
          if8.A = a;
          if8.B = b;
          if8.in_valid = 1'b1;
          while (!if8.in_ready && w < 60) begin
            @(negedge clk);
            w++;
          end
          if (!if8.in_ready) begin
            checks++;
            errors++;
            $display("FAIL rand8_ready_timeout op %0d in_ready=%b required 1", i, if8.in_ready);
            if8.in_valid = 1'b0;
            break;
          end
          q.push_back(16'(refmul(longint'(a), longint'(b), 8)));
          @(posedge clk);
          #1;
          if8.in_valid = 1'b0;
          if8.A = 8'($urandom);
          if8.B = 8'($urandom);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < n && cyc < n * 40) begin
          @(negedge clk);
          cyc++;
          if8.out_ready = 1'($urandom_range(0, 1));
          if (if8.out_valid && if8.out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rand8_spurious C=%h required no result", if8.C);
            end else begin
              if (if8.C !== q[0]) begin
                errors++;
                $display("FAIL rand8_result op %0d C=%h required %h", got, if8.C, q[0]);
              end
              $display("txn w8 rand %0d C=%h exp=%h", got, if8.C, q[0]);
              void'(q.pop_front());
            end
            got++;
          end
        end
        if8.out_ready = 1'b0;
        checks++;
        if (got != n) begin
          errors++;
          $display("FAIL rand8_count got %0d required %0d", got, n);
        end
      end
    join
  endtask

  task automatic test_random16(input int n);
    logic [31:0] q[$];
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int idle;
          int w;
          logic [15:0] a;
          logic [15:0] b;
          idle = $urandom_range(0, 3);
          w = 0;
          a = 16'($urandom);
          b = 16'($urandom);
          repeat (idle) @(negedge clk);
          if16.A = a;
          if16.B = b;
          if16.in_valid = 1'b1;
          while (!if16.in_ready && w < 60) begin
            @(negedge clk);
            w++;
          end
          if (!if16.in_ready) begin
            checks++;
            errors++;
            $display("FAIL rand16_ready_timeout op %0d in_ready=%b required 1", i, if16.in_ready);
            if16.in_valid = 1'b0;
            break;
          end
          q.push_back(32'(refmul(longint'(a), longint'(b), 16)));
          @(posedge clk);
          #1;
          if16.in_valid = 1'b0;
          if16.A = 16'($urandom);
          if16.B = 16'($urandom);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < n && cyc < n * 40) begin
          @(negedge clk);
          cyc++;
          if16.out_ready = 1'($urandom_range(0, 1));
          if (if16.out_valid && if16.out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rand16_spurious C=%h required no result", if16.C);
            end else begin
              if (if16.C !== q[0]) begin
                errors++;
                $display("FAIL rand16_result op %0d C=%h required %h", got, if16.C, q[0]);
              end
              $display("txn w16 rand %0d C=%h exp=%h", got, if16.C, q[0]);
              void'(q.pop_front());
            end
            got++;
          end
        end
        if16.out_ready = 1'b0;
        checks++;
        if (got != n) begin
          errors++;
          $display("FAIL rand16_count got %0d required %0d", got, n);
        end
      end
    join
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b0;
    if16.A = '0;
    if16.B = '0;
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b0;
    if8.A = '0;
    if8.B = '0;
    test_reset();
    test_directed16();
    test_backpressure();
    test_reset_abort();
    test_w8();
    test_random8(1000);
    test_random16(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
